// File: rtl/cic_decim_ctrl_pkg.sv
// ============================================================================
// cic_ctrl_pkg : shared types and constants for the CIC decimator sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int MIN_RATIO   = 2;
    localparam int RESET_RATIO = 4;

endpackage

`default_nettype wire

// File: rtl/cic_decim_ctrl_if.sv
// ============================================================================
// cic_decim_ctrl_if : valid/ready output stream of the CIC decimator
// Rev 1.0
// ============================================================================
`default_nettype none

interface cic_decim_ctrl_if #(
    parameter int DATA_W = 5
) ();

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/cic_decim_ctrl_out_fifo.sv
// ============================================================================
// cic_out_fifo : 2-entry output buffer with sticky overrun on dropped pushes
// Rev 1.0
// ============================================================================
`default_nettype none

module cic_out_fifo #(
    parameter int DATA_W = 5
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush_i,
    input  wire logic              push_i,
    input  wire logic [DATA_W-1:0] push_data_i,
    input  wire logic              ovr_clr_i,
    output      logic              overrun_o,
    cic_decim_ctrl_if.master       out_if
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              overrun_q;

    logic              w_pop;
    logic              w_full;
    logic              w_wr_ok;

    assign w_pop   = (count_q != 2'd0) && out_if.out_ready;
    assign w_full  = (count_q == 2'd2);
    // A pop frees the slot in the same cycle, so a push into a full buffer still lands.
    assign w_wr_ok = push_i && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_wr_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, w_wr_ok} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (ovr_clr_i) begin
            overrun_q <= 1'b0;
        end else if (push_i && w_full && !w_pop) begin
            overrun_q <= 1'b1;
        end
    end

    assign out_if.out_valid = (count_q != 2'd0);
    assign out_if.out_data  = mem_q[rd_ptr_q];
    assign overrun_o        = overrun_q;

endmodule

`default_nettype wire

// File: rtl/cic_decim_ctrl.sv
// ============================================================================
// cic_decim_ctrl : single-clock enable sequencer for a 1-bit-input CIC decimator
// Rev 1.0
// ============================================================================
`default_nettype none

module cic_decim_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int STAGES  = 2,
    parameter int RATIO_W = 8,
    parameter int DATA_W  = 5
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               en,
    input  wire logic               in_valid,
    input  wire logic               cfg_we,
    input  wire logic [RATIO_W-1:0] cfg_ratio,
    output      logic               dp_clr,
    output      logic               integ_en,
    output      logic               comb_en,
    input  wire logic [DATA_W-1:0]  comb_data,
    output      logic               overrun,
    output      logic               busy,
    cic_decim_ctrl_if.master        out_if
);

    localparam int                 FLUSH_W   = $clog2(STAGES + 1);
    localparam logic [RATIO_W-1:0] RATIO_ONE = RATIO_W'(1);
    localparam logic [RATIO_W-1:0] RATIO_MIN = RATIO_W'(MIN_RATIO);

    state_t               state_q, state_d;
    logic [RATIO_W-1:0]   ratio_q, ratio_d;
    logic [RATIO_W-1:0]   cnt_q, cnt_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                 dp_clr_q, dp_clr_d;
    logic                 comb_en_q, comb_en_d;

    logic                 w_cfg_acc;
    logic                 w_wrap;
    logic                 w_push;

    // The clear cycle is excluded so the first counted sample is also the first integrated one.
    assign integ_en = in_valid && (state_q != IDLE) && !dp_clr_q;
    assign w_wrap   = (cnt_q == ratio_q - RATIO_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ratio_q     <= RATIO_W'(RESET_RATIO);
            cnt_q       <= '0;
            flush_cnt_q <= '0;
            dp_clr_q    <= 1'b0;
            comb_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ratio_q     <= ratio_d;
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
            dp_clr_q    <= dp_clr_d;
            comb_en_q   <= comb_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ratio_d     = ratio_q;
        cnt_d       = cnt_q;
        flush_cnt_d = flush_cnt_q;
        dp_clr_d    = 1'b0;
        comb_en_d   = 1'b0;
        w_cfg_acc   = 1'b0;

        if (integ_en) begin
            cnt_d     = w_wrap ? '0 : cnt_q + RATIO_ONE;
            comb_en_d = w_wrap;
        end

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    w_cfg_acc = 1'b1;
                    ratio_d   = (cfg_ratio < RATIO_MIN) ? RATIO_MIN : cfg_ratio;
                end
                if (en) begin
                    state_d     = FLUSH;
                    dp_clr_d    = 1'b1;
                    cnt_d       = '0;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                if (comb_en_q) begin
                    if (flush_cnt_q != FLUSH_W'(STAGES)) begin
                        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                    end
                    if (flush_cnt_q == FLUSH_W'(STAGES - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping the run request aborts from any state on the next edge.
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            comb_en_d = 1'b0;
            dp_clr_d  = 1'b0;
        end
    end

    assign w_push = comb_en_q && (state_q == RUN) && en;

    cic_out_fifo #(
        .DATA_W (DATA_W)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (!en),
        .push_i      (w_push),
        .push_data_i (comb_data),
        .ovr_clr_i   (w_cfg_acc),
        .overrun_o   (overrun),
        .out_if      (out_if)
    );

    assign dp_clr  = dp_clr_q;
    assign comb_en = comb_en_q;
    assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cic_decim_ctrl.sv
// ============================================================================
// tb_cic_decim_ctrl : directed + randomized bench with a behavioural reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cic_decim_ctrl;

    localparam int STAGES  = 2;
    localparam int RATIO_W = 8;
    localparam int DATA_W  = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               in_valid;
    logic               cfg_we;
    logic [RATIO_W-1:0] cfg_ratio;
    logic               dp_clr;
    logic               integ_en;
    logic               comb_en;
    logic [DATA_W-1:0]  comb_data;
    logic               overrun;
    logic               busy;

    always #5 clk = ~clk;

    cic_decim_ctrl_if #(.DATA_W(DATA_W)) oif ();

    cic_decim_ctrl #(
        .STAGES  (STAGES),
        .RATIO_W (RATIO_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .cfg_we    (cfg_we),
        .cfg_ratio (cfg_ratio),
        .dp_clr    (dp_clr),
        .integ_en  (integ_en),
        .comb_en   (comb_en),
        .comb_data (comb_data),
        .overrun   (overrun),
        .busy      (busy),
        .out_if    (oif)
    );

    // Reference model: phase 0 idle, 1 discarding settle words, 2 delivering words
    int                m_phase;
    int                m_ratio;
    int                m_samples;
    int                m_discarded;
    bit                m_clr;
    bit                m_comb;
    bit                m_ovr;
    logic [DATA_W-1:0] m_buf [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_ratio     = 4;
        m_samples   = 0;
        m_discarded = 0;
        m_clr       = 1'b0;
        m_comb      = 1'b0;
        m_ovr       = 1'b0;
        m_buf.delete();
    endtask

    task automatic model_step(input bit sample_taken);
        bit cur_comb;
        bit wrap;
        bit pop;
        bit next_clr;
        if (rst) begin
            model_reset();
            return;
        end
        cur_comb = m_comb;
        next_clr = 1'b0;
        pop      = (m_buf.size() != 0) && oif.out_ready;
        wrap     = sample_taken && (m_samples == m_ratio - 1);

        if (m_phase == 0 && cfg_we) begin
            m_ratio = (cfg_ratio < 2) ? 2 : int'(cfg_ratio);
            m_ovr   = 1'b0;
        end

        if (sample_taken) m_samples = wrap ? 0 : m_samples + 1;

        if (!en) begin
            m_buf.delete();
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (m_phase == 2 && cur_comb) begin
                if (m_buf.size() < 2) m_buf.push_back(comb_data);
                else m_ovr = 1'b1;
            end
        end

        if (!en) begin
            m_phase   = 0;
            m_samples = 0;
        end else if (m_phase == 0) begin
            m_phase     = 1;
            next_clr    = 1'b1;
            m_samples   = 0;
            m_discarded = 0;
        end else if (m_phase == 1 && cur_comb) begin
            if (m_discarded < STAGES) m_discarded++;
            if (m_discarded == STAGES) m_phase = 2;
        end

        m_comb = wrap && en;
        m_clr  = next_clr;
    endtask

    // Inputs are set just after a negedge; outputs are checked 1 time unit later.
    task automatic cyc();
        bit exp_integ;
        #1;
        exp_integ = in_valid && (m_phase != 0) && !m_clr;
        chk("dp_clr", dp_clr, m_clr);
        chk("comb_en", comb_en, m_comb);
        chk("integ_en", integ_en, exp_integ);
        chk("out_valid", oif.out_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) chk("out_data", oif.out_data, m_buf[0]);
        chk("overrun", overrun, m_ovr);
        chk("busy", busy, m_phase != 0);
        model_step(exp_integ);
        @(negedge clk);
    endtask

    task automatic count_comb(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (comb_en) pulses++;
        end
    endtask

    initial begin
        int pulses;
        bit reached;
        logic [DATA_W-1:0] ramp;

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
        cfg_ratio = '0; comb_data = '0; oif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_out_data", oif.out_data, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);

        // R=4, continuous samples, consumer always ready
        cfg_we = 1'b1; cfg_ratio = 8'd4; cyc();
        cfg_we = 1'b0; en = 1'b1; in_valid = 1'b1; oif.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin comb_data = DATA_W'($urandom); cyc(); end
        count_comb(16, pulses);
        chk("period_r4", pulses, 4);

        // cfg_ratio=0 clamps to 2; cfg_we while running is ignored
        en = 1'b0; cyc(); cyc();
        cfg_we = 1'b1; cfg_ratio = 8'd0; cyc();
        cfg_we = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin comb_data = DATA_W'($urandom); cyc(); end
        cfg_we = 1'b1; cfg_ratio = 8'd9; cyc();
        cfg_we = 1'b0;
        count_comb(16, pulses);
        chk("period_r2_cfg_ignored", pulses, 8);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom); comb_data = DATA_W'($urandom); cyc();
        end

        // cfg_ratio=1 clamps to 2; stalled consumer forces a drop
        en = 1'b0; in_valid = 1'b1; cyc();
        cfg_we = 1'b1; cfg_ratio = 8'd1; cyc();
        cfg_we = 1'b0; en = 1'b1; oif.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin comb_data = DATA_W'($urandom); cyc(); end
        chk("overrun_set", overrun, 1);
        en = 1'b0; cyc();
        chk("overrun_sticky", overrun, 1);
        cfg_we = 1'b1; cfg_ratio = 8'd2; cyc();
        cfg_we = 1'b0;
        chk("overrun_clr", overrun, 0);

        // Ramp data with a random consumer: ordering and simultaneous push/pop
        en = 1'b1; ramp = '0;
        for (int i = 0; i < 60; i++) begin
            oif.out_ready = (i < 12) ? 1'b0 : 1'($urandom);
            comb_data = ramp; ramp = ramp + 1'b1;
            cyc();
        end

        // Abort with exactly one word buffered
        en = 1'b0; cyc();
        en = 1'b1; oif.out_ready = 1'b0; reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            comb_data = DATA_W'($urandom); cyc();
            reached = (m_phase == 2) && (m_buf.size() == 1);
        end
        chk("wait_one_word", reached, 1);
        chk("one_word_valid", oif.out_valid, 1);
        en = 1'b0; cyc();
        chk("abort_out_valid", oif.out_valid, 0);
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 16; i++) begin
            en = 1'b1; comb_data = DATA_W'($urandom); cyc();
        end

        // Reset pulse mid-settle brings the ratio back to 4
        en = 1'b0; cyc();
        cfg_we = 1'b1; cfg_ratio = 8'd7; cyc();
        cfg_we = 1'b0; en = 1'b1; oif.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; en = 1'b0; cyc();
        chk("rst_mid_flush_busy", busy, 0);
        en = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        count_comb(16, pulses);
        chk("period_after_rst", pulses, 4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            rst           = ($urandom_range(0, 149) == 0);
            in_valid      = 1'($urandom);
            oif.out_ready = 1'($urandom);
            cfg_we        = ($urandom_range(0, 7) == 0);
            cfg_ratio     = RATIO_W'($urandom_range(0, 6));
            comb_data     = DATA_W'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
